// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative cipher engines.
//   - 128-bit block type and FSM state encoding (IDLE/ROUND/DONE)
//   - S-box lookup, GF(2^8) helpers (xtime, gmul)
//   - key-schedule word helpers (rot_word, sub_word, rcon)
//   - rk_slice: pulls round key r out of a KeyExpansion result
// No ports; imported with "import aes_pkg::*".
package aes_pkg;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_fsm_e;

  // Widest expanded key (AES-256: 15 round keys); narrower schedules are
  // zero-extended to this width before slicing.
  localparam int AES_EK_MAX = 1920;

  // Forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[2047 - 8*int'(b) -: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) product, shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) begin
        acc = acc ^ p;
      end else begin
        acc = acc;
      end
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Round constant for schedule step j (j >= 1): x^(j-1).
  function automatic logic [7:0] rcon(input int j);
    logic [7:0] v;
    v = 8'h01;
    for (int k = 1; k < j; k++) begin
      v = xtime(v);
    end
    return v;
  endfunction

  // Round key r sits at the top of the expanded key for r = 0 and moves
  // down 128 bits per round.
  function automatic aes_block_t rk_slice(input logic [AES_EK_MAX-1:0] ek,
                                          input int nr, input int r);
    return ek[128*(nr+1)-1-128*r -: 128];
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round.
// Ports:
//   state       in  128  round input, byte 0 in bits [127:120]
//   round_key   in  128  key added at the end of the round
//   last_round  in  1    skip MixColumns (final round)
//   result      out 128  SubBytes/ShiftRows/[MixColumns]/AddRoundKey
module aes_enc_round
  import aes_pkg::*;
(
  input  aes_block_t state,
  input  aes_block_t round_key,
  input  logic       last_round,
  output aes_block_t result
);

  logic [7:0] sb_s [16];
  logic [7:0] sr_s [16];
  logic [7:0] mc_s [16];
  aes_block_t sr_blk_s;
  aes_block_t mc_blk_s;

  // Byte i is row i%4, column i/4; row r rotates left by r columns.
  always_comb begin
    sr_blk_s = '0;
    mc_blk_s = '0;
    for (int i = 0; i < 16; i++) begin
      sb_s[i] = sbox(state[127-8*i -: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_s[4*c+r] = sb_s[4*((c+r)%4)+r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc_s[4*c]   = xtime(sr_s[4*c]) ^ gmul(sr_s[4*c+1], 8'h03)
                    ^ sr_s[4*c+2] ^ sr_s[4*c+3];
      mc_s[4*c+1] = sr_s[4*c] ^ xtime(sr_s[4*c+1])
                    ^ gmul(sr_s[4*c+2], 8'h03) ^ sr_s[4*c+3];
      mc_s[4*c+2] = sr_s[4*c] ^ sr_s[4*c+1]
                    ^ xtime(sr_s[4*c+2]) ^ gmul(sr_s[4*c+3], 8'h03);
      mc_s[4*c+3] = gmul(sr_s[4*c], 8'h03) ^ sr_s[4*c+1]
                    ^ sr_s[4*c+2] ^ xtime(sr_s[4*c+3]);
    end
    for (int i = 0; i < 16; i++) begin
      sr_blk_s[127-8*i -: 8] = sr_s[i];
      mc_blk_s[127-8*i -: 8] = mc_s[i];
    end
  end

  // Final round bypasses MixColumns before the key add.
  always_comb begin
    if (last_round) begin
      result = sr_blk_s ^ round_key;
    end else begin
      result = mc_blk_s ^ round_key;
    end
  end

endmodule

// File: rtl/aes_key_expand.sv
// Combinational AES KeyExpansion (FIPS-197 5.2) for 128/192/256-bit keys.
// Ports:
//   key  in  32*NK        cipher key, key byte 0 in the top byte
//   ek   out 128*(NR+1)   round keys concatenated, round 0 in the top bits
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NR = 10,
  parameter int NK = 4
) (
  input  logic [32*NK-1:0]      key,
  output logic [128*(NR+1)-1:0] ek
);

  localparam int NW = 4*(NR+1);

  logic [31:0] w_s [NW];
  logic [31:0] tmp_s;

  // Word-by-word schedule; each word depends only on earlier ones.
  always_comb begin
    ek    = '0;
    tmp_s = 32'h0;
    for (int i = 0; i < NW; i++) begin
      if (i < NK) begin
        w_s[i] = key[32*NK-1-32*i -: 32];
      end else begin
        if (i % NK == 0) begin
          tmp_s = sub_word(rot_word(w_s[i-1])) ^ {rcon(i/NK), 24'h000000};
        end else if ((NK > 6) && (i % NK == 4)) begin
          // AES-256 only: extra SubWord halfway through each key period
          tmp_s = sub_word(w_s[i-1]);
        end else begin
          tmp_s = w_s[i-1];
        end
        w_s[i] = w_s[i-NK] ^ tmp_s;
      end
      ek[128*(NR+1)-1-32*i -: 32] = w_s[i];
    end
  end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128/192/256 encryption engine, one round per clock.
// Ports:
//   clk, rst    clock (rising edge), asynchronous active-high reset
//   in_valid    plaintext/key offered; taken only while in_ready
//   in_ready    high in IDLE (combinational from the FSM state)
//   in_block    plaintext, byte 0 in [127:120]
//   in_key      cipher key (32*NK bits), key byte 0 in the top byte
//   out_valid   ciphertext valid (registered)
//   out_ready   consumer acceptance, only used with AES_ENC_BACKPRESSURE_EN
//   out_block   ciphertext (registered), held after completion
//   busy        high in ROUND and DONE
// Build option AES_ENC_BACKPRESSURE_EN: DONE holds out_valid until
// out_ready; when undefined out_valid is a single-cycle pulse.
module aes_cipher_iter
  import aes_pkg::*;
#(
  parameter int NR = 10,
  parameter int NK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_block,
  input  logic [32*NK-1:0] in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_block,
  output logic             busy
);

  localparam int RW  = $clog2(NR+1);
  localparam int EKW = 128*(NR+1);

  localparam logic [RW-1:0] RND_ZERO  = RW'(0);
  localparam logic [RW-1:0] RND_FIRST = RW'(1);
  localparam logic [RW-1:0] RND_LAST  = RW'(NR);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ROUND = ROUND;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]            fsm_r;
  logic [RW-1:0]         rnd_r;
  logic [32*NK-1:0]      key_r;
  aes_block_t            state_r;

  logic [EKW-1:0]        ek_s;
  logic [AES_EK_MAX-1:0] ek_pad_s;
  aes_block_t            rk_s;
  aes_block_t            round_s;
  logic                  last_s;

`ifndef AES_ENC_BACKPRESSURE_EN
  logic unused_out_ready_s;
  assign unused_out_ready_s = out_ready;
`endif

  aes_key_expand #(
    .NR (NR),
    .NK (NK)
  ) u_key_expand (
    .key (key_r),
    .ek  (ek_s)
  );

  aes_enc_round u_round (
    .state      (state_r),
    .round_key  (rk_s),
    .last_round (last_s),
    .result     (round_s)
  );

  assign ek_pad_s = AES_EK_MAX'(ek_s);
  assign rk_s     = rk_slice(ek_pad_s, NR, int'(rnd_r));
  assign last_s   = (rnd_r == RND_LAST);

  assign in_ready = (fsm_r == ST_IDLE);
  assign busy     = (fsm_r == ST_ROUND) || (fsm_r == ST_DONE);

  // FSM, round counter, key/state registers and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_r     <= ST_IDLE;
      rnd_r     <= RND_ZERO;
      key_r     <= '0;
      state_r   <= '0;
      out_block <= '0;
      out_valid <= 1'b0;
    end else begin
      case (fsm_r)
        ST_IDLE: begin
          if (in_valid) begin
            // Round 0 key is the first 128 key bits; take it straight from
            // the port so the schedule can settle from key_r for round 1.
            key_r   <= in_key;
            state_r <= in_block ^ in_key[32*NK-1 -: 128];
            rnd_r   <= RND_FIRST;
            fsm_r   <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          state_r <= round_s;
          if (last_s) begin
            // Counter stays at NR; it is cleared on the way back to IDLE.
            out_block <= round_s;
            out_valid <= 1'b1;
            fsm_r     <= ST_DONE;
          end else begin
            rnd_r <= rnd_r + RND_FIRST;
          end
        end
        ST_DONE: begin
`ifdef AES_ENC_BACKPRESSURE_EN
          if (out_ready) begin
            out_valid <= 1'b0;
            rnd_r     <= RND_ZERO;
            fsm_r     <= ST_IDLE;
          end
`else
          out_valid <= 1'b0;
          rnd_r     <= RND_ZERO;
          fsm_r     <= ST_IDLE;
`endif
        end
        default: begin
          out_valid <= 1'b0;
          rnd_r     <= RND_ZERO;
          fsm_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed bench for aes_cipher_iter: FIPS-197 vectors for AES-128/192/256,
// latency, handshake, mid-operation reset and output hold/pulse behaviour.
module tb_aes_cipher_iter;

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk;
  logic         rst;
  logic         out_ready;
  logic [127:0] in_block;
  logic         iv10, iv12, iv14;
  logic [127:0] key10;
  logic [191:0] key12;
  logic [255:0] key14;
  logic         ir10, ir12, ir14;
  logic         ov10, ov12, ov14;
  logic         bz10, bz12, bz14;
  logic [127:0] ob10, ob12, ob14;

  int nvec;
  int nmis;
  int lat;
  logic seen;

  aes_cipher_iter #(.NR(10), .NK(4)) u_dut10 (
    .clk(clk), .rst(rst), .in_valid(iv10), .in_ready(ir10),
    .in_block(in_block), .in_key(key10), .out_valid(ov10),
    .out_ready(out_ready), .out_block(ob10), .busy(bz10)
  );

  aes_cipher_iter #(.NR(12), .NK(6)) u_dut12 (
    .clk(clk), .rst(rst), .in_valid(iv12), .in_ready(ir12),
    .in_block(in_block), .in_key(key12), .out_valid(ov12),
    .out_ready(out_ready), .out_block(ob12), .busy(bz12)
  );

  aes_cipher_iter #(.NR(14), .NK(8)) u_dut14 (
    .clk(clk), .rst(rst), .in_valid(iv14), .in_ready(ir14),
    .in_block(in_block), .in_key(key14), .out_valid(ov14),
    .out_ready(out_ready), .out_block(ob14), .busy(bz14)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Counts edges after the acceptance edge until out_valid is seen at a
  // negedge; lat = -1 when the budget runs out.
  task automatic wait_valid(input int sel, input int budget, output int l);
    logic v;
    logic found;
    l = -1;
    found = 1'b0;
    for (int n = 1; n <= budget; n++) begin
      if (!found) begin
        @(posedge clk);
        @(negedge clk);
        case (sel)
          10:      v = ov10;
          12:      v = ov12;
          default: v = ov14;
        endcase
        if (v) begin
          l = n;
          found = 1'b1;
        end
      end
    end
  endtask

  // Offers one block to the NR=10 engine for a single edge (called at a negedge).
  task automatic accept10(input logic [127:0] blk, input logic [127:0] k);
    in_block = blk;
    key10 = k;
    iv10 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv10 = 1'b0;
  endtask

  initial begin
    nvec = 0;
    nmis = 0;
    rst = 1'b1;
    out_ready = 1'b1;
    in_block = '0;
    iv10 = 1'b0; iv12 = 1'b0; iv14 = 1'b0;
    key10 = '0; key12 = '0; key14 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 128'(ov10), 128'd0);
    chk("rst_out_block", ob10, 128'd0);
    chk("rst_busy", 128'(bz10), 128'd0);
    chk("rst_in_ready", 128'(ir10), 128'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 128'(ir10), 128'd1);

    // FIPS-197 C.1, latency 10
    accept10(PT, K128);
    chk("c1_in_ready_busy", 128'(ir10), 128'd0);
    chk("c1_busy", 128'(bz10), 128'd1);
    wait_valid(10, 40, lat);
    chk("c1_latency", 128'(lat), 128'd10);
    chk("c1_out_block", ob10, CT128);
    @(negedge clk);
    chk("c1_pulse_end", 128'(ov10), 128'd0);
    chk("c1_ready_again", 128'(ir10), 128'd1);
    chk("c1_busy_end", 128'(bz10), 128'd0);

    // Consumer not ready while the block completes
    out_ready = 1'b0;
    accept10(PT, K128);
    wait_valid(10, 40, lat);
    chk("or_latency", 128'(lat), 128'd10);
    chk("or_out_block", ob10, CT128);
`ifdef AES_ENC_BACKPRESSURE_EN
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", 128'(ov10), 128'd1);
      chk("bp_hold_block", ob10, CT128);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 128'(ov10), 128'd0);
    chk("bp_release_ready", 128'(ir10), 128'd1);
`else
    @(negedge clk);
    chk("nbp_pulse_valid", 128'(ov10), 128'd0);
    chk("nbp_ready", 128'(ir10), 128'd1);
    out_ready = 1'b1;
`endif

    // in_valid held, inputs changed mid-block; next block at k+NR+2
    in_block = PT;
    key10 = K128;
    iv10 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_block = ~PT;
    key10 = ~K128;
    chk("hold_in_ready", 128'(ir10), 128'd0);
    wait_valid(10, 40, lat);
    chk("hold_latency", 128'(lat), 128'd10);
    chk("hold_out_block", ob10, CT128);
    @(negedge clk);
    chk("hold_idle_ready", 128'(ir10), 128'd1);
    @(negedge clk);
    iv10 = 1'b0;
    chk("b2b_accepted", 128'(bz10), 128'd1);
    wait_valid(10, 40, lat);
    chk("b2b_latency", 128'(lat), 128'd10);
    @(negedge clk);

    // Reset during round 5
    accept10(PT, K128);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 128'(ov10), 128'd0);
    chk("mid_rst_block", ob10, 128'd0);
    chk("mid_rst_busy", 128'(bz10), 128'd0);
    chk("mid_rst_ready", 128'(ir10), 128'd1);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (ov10) begin
        seen = 1'b1;
      end
    end
    chk("mid_rst_no_valid", 128'(seen), 128'd0);
    accept10(PT, K128);
    wait_valid(10, 40, lat);
    chk("post_rst_latency", 128'(lat), 128'd10);
    chk("post_rst_block", ob10, CT128);
    @(negedge clk);

    // AES-192
    chk("k192_ready", 128'(ir12), 128'd1);
    in_block = PT;
    key12 = K192;
    iv12 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv12 = 1'b0;
    wait_valid(12, 40, lat);
    chk("k192_latency", 128'(lat), 128'd12);
    chk("k192_out_block", ob12, CT192);
    @(negedge clk);

    // AES-256
    chk("k256_ready", 128'(ir14), 128'd1);
    in_block = PT;
    key14 = K256;
    iv14 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv14 = 1'b0;
    wait_valid(14, 40, lat);
    chk("k256_latency", 128'(lat), 128'd14);
    chk("k256_out_block", ob14, CT256);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
